alu_flag_mem_unit: RTL and testbench
====================================

# alu_flag_mem_unit

Execute/memory datapath slice of the 64-bit pipelined CPU. It contains a combinational 64-bit ALU with NZVC flag generation, an enable-gated architectural flag register, and a byte-addressed data memory with synchronous write and combinational read. Decode, forwarding and pipeline registers feed it from outside, and the register writeback mux consumes its outputs.

## Interface
Parameters:
- `DATA_W`, 64: datapath width; fixed at 64.
- `MEM_BYTES`, 1024: data memory size in bytes; must be a power of two and at least 8.

Ports:
- `clk`, in, 1: single clock; all state updates occur on the rising edge.
- `reset`, in, 1: reset is synchronous and active-low.
- `a`, in, 64: ALU operand A.
- `b`, in, 64: ALU operand B.
- `cntrl`, in, 3: ALU operation select.
- `result`, out, 64: ALU result (combinational).
- `tmp_n`, `tmp_z`, `tmp_v`, `tmp_c`, out, 1 each: flags of the current ALU operation (combinational).
- `flag_en`, in, 1: load the flag register on this edge.
- `negative`, `zero`, `overflow`, `carry_out`, out, 1 each: registered flags.
- `mem_addr`, in, 64: byte address.
- `mem_wdata`, in, 64: store data.
- `mem_we`, in, 1: write enable.
- `mem_re`, in, 1: read enable.
- `xfer_size`, in, 4: access size in bytes; legal values are 1, 2, 4 and 8.
- `mem_rdata`, out, 64: load data (combinational).

## Operation
ALU, selected by `cntrl`:
- 000: `result` = B.
- 010: `result` = A+B.
- 011: `result` = A−B, computed as A+~B+1.
- 100: `result` = A&B.
- 101: `result` = A|B.
- 110: `result` = A^B.
- 001 and 111: `result` = 0.

ALU flags:
- `tmp_n` = result[63].
- `tmp_z` = 1 when result == 0.
- `tmp_c`: carry-out of bit 63 of the adder. For subtract, C=1 means no borrow.
- `tmp_v`: signed overflow, i.e. the carry into bit 63 XOR the carry out of bit 63.
- For all non-add/sub codes, `tmp_c` = `tmp_v` = 0.
- All arithmetic wraps modulo 2^64.

Flag register:
- When `reset` is low at an edge: all four registered flags become 0.
- Otherwise, when `flag_en` is high: load `tmp_n/z/v/c`.
- Otherwise: hold.

Memory addressing:
- The effective index is `mem_addr` modulo `MEM_BYTES`; upper address bits are ignored, so accesses wrap.
- Byte order is little-endian: the byte at the lowest address maps to bits [7:0].

Memory write:
- On the rising edge with `mem_we`=1, write the low `xfer_size` bytes of `mem_wdata`.
- The write is suppressed when the address is not a multiple of `xfer_size`, or when `xfer_size` is not a legal value.

Memory read:
- With `mem_re`=1, `mem_rdata` is the `xfer_size` bytes at the address, zero-extended to 64 bits.
- `mem_rdata` = 0 when `mem_re`=0, on a misaligned address, or on an illegal size.

Memory boundary rules:
- Reset does not alter memory contents.
- All bytes are 0 at time zero.
- `mem_we` and `mem_re` may both be high. Before the edge, the read returns the old data; after the edge, it returns the new data.
- `mem_we` and `mem_re` are independent of `flag_en`.

## Timing
- `result`, `tmp_*` and `mem_rdata` are combinational, with 0 cycles of latency.
- Registered flags update 1 edge after `flag_en`. The caller performs any same-cycle flag bypass (`flag_en` ? `tmp_*` : registered).
- A store is visible to a read in the cycle after its edge.
- Reset value of every registered output is 0. Memory is unaffected by reset.
- Reset asserted in the middle of a store: the store is still performed on that edge, since reset only affects the flag register.

## Structure
- Shared package `cpu_pkg`:
  - `alu_op_t` enum (PASS_B=000, ADD=010, SUB=011, AND=100, OR=101, XOR=110).
  - `flags_t` struct {n,z,v,c}.
  - `DATA_W`.
- Sub-module `alu64` holds the ALU and flag generation.
- The flag register and the memory array live in the top.

## Test plan
- ADD: `a`=5, `b`=7 → `result`=12 and n,z,v,c = 0,0,0,0. Then `flag_en`=1 for one edge → registered flags = 0000.
- SUB: `a`=3, `b`=5 → `result`=0xFFFF_FFFF_FFFF_FFFE with N=1, C=0, V=0. SUB 5−5 → Z=1, C=1.
- Overflow: ADD 0x7FFF_FFFF_FFFF_FFFF + 1 → 0x8000_0000_0000_0000 with N=1, V=1, C=0. ADD 0xFFFF…FFFF + 1 → 0 with Z=1, C=1, V=0.
- Flag hold and reset:
  - Load N=1.
  - Then `flag_en`=0 with a zero-result op → `negative` stays 1.
  - Then `reset`=0 for one edge → all flags 0.
- Memory:
  - Store 0x1122_3344_5566_7788 at address 8, size 8. Next cycle, read at 8 → same value.
  - Read at 8, size 1 → 0x88.
  - Read at 9, size 1 → 0x77.
  - Read with `mem_re`=0 → 0.
- Misaligned and wrap:
  - Store at address 4, size 8 → memory unchanged, and a read there returns 0.
  - Store at `MEM_BYTES`+16 → readable at address 16.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the execute/memory slice: ALU opcodes, flag bundle, width.
package cpu_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    PASS_B = 3'b000,
    ADD    = 3'b010,
    SUB    = 3'b011,
    AND    = 3'b100,
    OR     = 3'b101,
    XOR    = 3'b110
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

endpackage

// File: rtl/alu64.sv
// Combinational 64-bit ALU with NZVC flag generation.
module alu64
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        cntrl,
  output logic [DATA_W-1:0] result,
  output flags_t            flags
);

  logic              subSel;
  logic [DATA_W-1:0] bOp;
  logic [DATA_W:0]   sumWide;
  logic              carryIn63;
  logic              isArith;
  logic [DATA_W-1:0] res;

  // Subtract shares the adder as A + ~B + 1.
  assign subSel    = (cntrl == SUB);
  assign bOp       = subSel ? ~b : b;
  assign sumWide   = {1'b0, a} + {1'b0, bOp} + {{DATA_W{1'b0}}, subSel};
  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the XOR.
  assign carryIn63 = sumWide[DATA_W-1] ^ a[DATA_W-1] ^ bOp[DATA_W-1];

  // Operation select; unused codes produce zero.
  always_comb begin
    res     = '0;
    isArith = 1'b0;
    case (cntrl)
      PASS_B:   res = b;
      ADD, SUB: begin
        res     = sumWide[DATA_W-1:0];
        isArith = 1'b1;
      end
      AND:      res = a & b;
      OR:       res = a | b;
      XOR:      res = a ^ b;
      default:  res = '0;
    endcase
  end

  assign result  = res;
  assign flags.n = res[DATA_W-1];
  assign flags.z = (res == '0);
  assign flags.c = isArith & sumWide[DATA_W];
  assign flags.v = isArith & (carryIn63 ^ sumWide[DATA_W]);

endmodule

// File: rtl/alu_flag_mem_unit.sv
// Execute/memory slice: ALU, architectural flag register, byte-addressed data memory.
module alu_flag_mem_unit #(
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        cntrl,
  output logic [DATA_W-1:0] result,
  output logic              tmp_n,
  output logic              tmp_z,
  output logic              tmp_v,
  output logic              tmp_c,
  input  logic              flag_en,
  output logic              negative,
  output logic              zero,
  output logic              overflow,
  output logic              carry_out,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_we,
  input  logic              mem_re,
  input  logic [3:0]        xfer_size,
  output logic [DATA_W-1:0] mem_rdata
);

  import cpu_pkg::*;

  localparam int AW = $clog2(MEM_BYTES);

  flags_t aluFlags;
  flags_t flagReg;

  alu64 uAlu (
    .a      (a),
    .b      (b),
    .cntrl  (cntrl),
    .result (result),
    .flags  (aluFlags)
  );

  assign tmp_n = aluFlags.n;
  assign tmp_z = aluFlags.z;
  assign tmp_v = aluFlags.v;
  assign tmp_c = aluFlags.c;

  // Flag register: cleared by reset, loaded when enabled, otherwise held.
  always_ff @(posedge clk) begin
    if (!reset)
      flagReg <= '0;
    else if (flag_en)
      flagReg <= aluFlags;
  end

  assign negative  = flagReg.n;
  assign zero      = flagReg.z;
  assign overflow  = flagReg.v;
  assign carry_out = flagReg.c;

  // Data memory is outside the reset domain; upper address bits wrap.
  logic [7:0]    mem [MEM_BYTES];
  logic [AW-1:0] idx;
  logic          sizeOk;
  logic          aligned;
  logic          accessOk;

  assign idx      = mem_addr[AW-1:0];
  assign sizeOk   = (xfer_size == 4'd1) || (xfer_size == 4'd2) ||
                    (xfer_size == 4'd4) || (xfer_size == 4'd8);
  assign aligned  = ((mem_addr & (DATA_W'(xfer_size) - DATA_W'(1))) == '0);
  assign accessOk = sizeOk && aligned;

  // Store the low xfer_size bytes little-endian; bad size/alignment drops the write.
  always_ff @(posedge clk) begin
    if (mem_we && accessOk) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < xfer_size)
          mem[idx + AW'(i)] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Zero-extended combinational load; zero whenever the access is not valid.
  always_comb begin
    mem_rdata = '0;
    if (mem_re && accessOk) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < xfer_size)
          mem_rdata[8*i +: 8] = mem[idx + AW'(i)];
      end
    end
  end

endmodule

// File: tb/tb_alu_flag_mem_unit.sv
// Bench for alu_flag_mem_unit: vector table, corner sequences, randomized model check.
module tb_alu_flag_mem_unit;

  localparam int MB = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] a, b;
  logic [2:0]  cntrl;
  logic [63:0] result;
  logic        tmp_n, tmp_z, tmp_v, tmp_c;
  logic        flag_en;
  logic        negative, zero, overflow, carry_out;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_we, mem_re;
  logic [3:0]  xfer_size;
  logic [63:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0] refMem [MB];
  logic [3:0] refFlags;

  always #5 clk = ~clk;

  alu_flag_mem_unit #(.DATA_W(64), .MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .cntrl(cntrl), .result(result),
    .tmp_n(tmp_n), .tmp_z(tmp_z), .tmp_v(tmp_v), .tmp_c(tmp_c),
    .flag_en(flag_en), .negative(negative), .zero(zero), .overflow(overflow),
    .carry_out(carry_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .xfer_size(xfer_size), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [63:0] expR;
    logic [3:0]  expF;  // {n,z,v,c}
  } aluVec_t;

  aluVec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU straight from the arithmetic definitions.
  function automatic void aluRef(input logic [63:0] x, input logic [63:0] y, input logic [2:0] op,
                                 output logic [63:0] r, output logic [3:0] f);
    logic [64:0] wide;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'b000: r = y;
      3'b010: begin
        wide = {1'b0, x} + {1'b0, y};
        r = wide[63:0];
        c = wide[64];
        v = (x[63] == y[63]) && (r[63] != x[63]);
      end
      3'b011: begin
        r = x - y;
        c = (x >= y);
        v = (x[63] != y[63]) && (r[63] != x[63]);
      end
      3'b100: r = x & y;
      3'b101: r = x | y;
      3'b110: r = x ^ y;
      default: r = 64'd0;
    endcase
    f = {r[63], (r == 64'd0), v, c};
  endfunction

  function automatic logic accessLegal(input logic [63:0] addr, input logic [3:0] sz);
    if (!(sz == 1 || sz == 2 || sz == 4 || sz == 8)) return 1'b0;
    return (addr % 64'(sz)) == 0;
  endfunction

  function automatic logic [63:0] refRead(input logic [63:0] addr, input logic [3:0] sz, input logic re);
    logic [63:0] d;
    d = 64'd0;
    if (re && accessLegal(addr, sz))
      for (int i = 0; i < int'(sz); i++)
        d = d | (64'(refMem[int'((addr + 64'(i)) % MB)]) << (8 * i));
    return d;
  endfunction

  task automatic refWrite(input logic [63:0] addr, input logic [3:0] sz, input logic [63:0] d);
    if (accessLegal(addr, sz))
      for (int i = 0; i < int'(sz); i++)
        refMem[int'((addr + 64'(i)) % MB)] = d[8*i +: 8];
  endtask

  task automatic memOp(input logic [63:0] addr, input logic [3:0] sz, input logic we,
                       input logic re, input logic [63:0] d);
    mem_addr  = addr;
    xfer_size = sz;
    mem_we    = we;
    mem_re    = re;
    mem_wdata = d;
  endtask

  initial begin
    logic [63:0] r;
    logic [3:0]  f;
    logic [3:0]  sizes [11];
    logic [63:0] addr;
    logic [3:0]  sz;
    logic        we, re;
    logic [63:0] wd;

    sizes = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0, 4'd5};
    for (int i = 0; i < MB; i++) refMem[i] = 8'h00;

    reset = 1'b0; a = '0; b = '0; cntrl = 3'b000; flag_en = 1'b0;
    memOp(64'd0, 4'd8, 1'b0, 1'b0, 64'd0);
    step();
    step();
    check("reset_flags", 64'({negative, zero, overflow, carry_out}), 64'h0);
    reset = 1'b1;

    // Bring the whole memory to a known zero state.
    for (int i = 0; i < MB / 8; i++) begin
      memOp(64'(i * 8), 4'd8, 1'b1, 1'b0, 64'd0);
      step();
    end
    memOp(64'd0, 4'd8, 1'b0, 1'b0, 64'd0);

    vecs.push_back('{64'd5, 64'd7, 3'b010, 64'd12, 4'b0000});
    vecs.push_back('{64'd3, 64'd5, 3'b011, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000});
    vecs.push_back('{64'd5, 64'd5, 3'b011, 64'd0, 4'b0101});
    vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'h8000_0000_0000_0000, 4'b1010});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'd0, 4'b0101});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'd1, 3'b011, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011});
    vecs.push_back('{64'hF0F0, 64'hFF00, 3'b100, 64'hF000, 4'b0000});
    vecs.push_back('{64'hF0F0, 64'hFF00, 3'b101, 64'hFFF0, 4'b0000});
    vecs.push_back('{64'hFF, 64'hFF, 3'b110, 64'd0, 4'b0100});
    vecs.push_back('{64'd9, 64'h8000_0000_0000_0001, 3'b000, 64'h8000_0000_0000_0001, 4'b1000});
    vecs.push_back('{64'd5, 64'd7, 3'b001, 64'd0, 4'b0100});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b111, 64'd0, 4'b0100});

    foreach (vecs[k]) begin
      a = vecs[k].a; b = vecs[k].b; cntrl = vecs[k].op;
      #1;
      check($sformatf("vec%0d_result", k), result, vecs[k].expR);
      check($sformatf("vec%0d_tmpflags", k), 64'({tmp_n, tmp_z, tmp_v, tmp_c}), 64'(vecs[k].expF));
      flag_en = 1'b1;
      step();
      flag_en = 1'b0;
      check($sformatf("vec%0d_regflags", k), 64'({negative, zero, overflow, carry_out}), 64'(vecs[k].expF));
    end

    // Flag hold and reset.
    a = 64'd3; b = 64'd5; cntrl = 3'b011; flag_en = 1'b1;
    step();
    check("hold_load_n", 64'(negative), 64'd1);
    cntrl = 3'b001; flag_en = 1'b0;
    step();
    check("hold_keep", 64'({negative, zero, overflow, carry_out}), 64'b1000);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("reset_clears", 64'({negative, zero, overflow, carry_out}), 64'h0);

    // Store/load, byte lanes, read enable.
    memOp(64'd8, 4'd8, 1'b1, 1'b0, 64'h1122_3344_5566_7788);
    step();
    memOp(64'd8, 4'd8, 1'b0, 1'b1, 64'd0); #1;
    check("load8", mem_rdata, 64'h1122_3344_5566_7788);
    memOp(64'd8, 4'd1, 1'b0, 1'b1, 64'd0); #1;
    check("load_byte8", mem_rdata, 64'h88);
    memOp(64'd9, 4'd1, 1'b0, 1'b1, 64'd0); #1;
    check("load_byte9", mem_rdata, 64'h77);
    memOp(64'd10, 4'd2, 1'b0, 1'b1, 64'd0); #1;
    check("load_half10", mem_rdata, 64'h5566);
    memOp(64'd12, 4'd4, 1'b0, 1'b1, 64'd0); #1;
    check("load_word12", mem_rdata, 64'h1122_3344);
    memOp(64'd8, 4'd8, 1'b0, 1'b0, 64'd0); #1;
    check("load_re_off", mem_rdata, 64'd0);
    memOp(64'd8, 4'd3, 1'b0, 1'b1, 64'd0); #1;
    check("load_bad_size", mem_rdata, 64'd0);

    // Misaligned store is dropped, misaligned read returns zero.
    memOp(64'd4, 4'd8, 1'b1, 1'b0, 64'hDEAD_BEEF_CAFE_F00D);
    step();
    memOp(64'd4, 4'd8, 1'b0, 1'b1, 64'd0); #1;
    check("misaligned_read", mem_rdata, 64'd0);
    memOp(64'd0, 4'd8, 1'b0, 1'b1, 64'd0); #1;
    check("misaligned_nowrite0", mem_rdata, 64'd0);
    memOp(64'd8, 4'd8, 1'b0, 1'b1, 64'd0); #1;
    check("misaligned_nowrite8", mem_rdata, 64'h1122_3344_5566_7788);

    // Address wrap.
    memOp(64'(MB + 16), 4'd8, 1'b1, 1'b0, 64'hA5A5_0000_1234_5678);
    step();
    memOp(64'd16, 4'd8, 1'b0, 1'b1, 64'd0); #1;
    check("wrap_read", mem_rdata, 64'hA5A5_0000_1234_5678);

    // Simultaneous read/write: old data before the edge, new data after.
    memOp(64'd16, 4'd4, 1'b1, 1'b1, 64'h0000_0000_FFEE_DDCC); #1;
    check("rw_before", mem_rdata, 64'h1234_5678);
    step();
    check("rw_after", mem_rdata, 64'hFFEE_DDCC);

    // Reset during a store: store still happens, flags clear.
    a = 64'd3; b = 64'd5; cntrl = 3'b011; flag_en = 1'b1;
    memOp(64'd8, 4'd8, 1'b0, 1'b0, 64'd0);
    step();
    reset = 1'b0;
    memOp(64'd24, 4'd8, 1'b1, 1'b0, 64'h0BAD_F00D_0000_0042);
    step();
    reset = 1'b1; flag_en = 1'b0;
    check("reset_store_flags", 64'({negative, zero, overflow, carry_out}), 64'h0);
    memOp(64'd24, 4'd8, 1'b0, 1'b1, 64'd0); #1;
    check("reset_store_data", mem_rdata, 64'h0BAD_F00D_0000_0042);

    // Sync the reference memory with the directed stores above.
    refWrite(64'd8, 4'd8, 64'h1122_3344_5566_7788);
    refWrite(64'd16, 4'd8, 64'h0000_0000_FFEE_DDCC & 64'hFFFF_FFFF);
    refWrite(64'd20, 4'd4, 64'hA5A5_0000);
    refWrite(64'd24, 4'd8, 64'h0BAD_F00D_0000_0042);
    refFlags = 4'b0000;

    // Randomized traffic against the reference model.
    for (int it = 0; it < 400; it++) begin
      a = {$urandom(), $urandom()};
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom(), $urandom()};
      cntrl = 3'($urandom_range(0, 7));
      flag_en = 1'($urandom_range(0, 1));
      addr = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) != 0) addr[2:0] = 3'b000;
      sz = sizes[$urandom_range(0, 10)];
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 3) != 0);
      wd = {$urandom(), $urandom()};
      memOp(addr, sz, we, re, wd);
      #1;
      aluRef(a, b, cntrl, r, f);
      check($sformatf("rnd%0d_result", it), result, r);
      check($sformatf("rnd%0d_tmpflags", it), 64'({tmp_n, tmp_z, tmp_v, tmp_c}), 64'(f));
      check($sformatf("rnd%0d_rdata", it), mem_rdata, refRead(addr, sz, re));
      step();
      if (flag_en) refFlags = f;
      if (we) refWrite(addr, sz, wd);
      check($sformatf("rnd%0d_regflags", it), 64'({negative, zero, overflow, carry_out}), 64'(refFlags));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
